frame_sram_arbiter: RTL

// Shares the single frame-buffer SRAM between the VGA display refresh path (read-only)
// and the graphics controller drawing engine (pixel read/write).

---
 rtl/frame_sram_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/frame_sram_arbiter.sv
// Frame-buffer SRAM arbiter: video refresh reads have priority over drawing-engine
// accesses, and a starvation counter bounds how long the drawing engine can wait.
module frame_sram_arbiter #(
  parameter int ADDR_W           = 18,
  parameter int DATA_W           = 16,
  parameter int ACCESS_CYCLES    = 2,
  parameter int GFX_STARVE_LIMIT = 8
) (
  input  logic              Clk,
  input  logic              Reset_H,
  input  logic              Vid_Req_H,
  input  logic [ADDR_W-1:0] Vid_Addr,
  output logic              Vid_Ack_H,
  output logic [DATA_W-1:0] Vid_RData,
  input  logic              Gfx_Req_H,
  input  logic              Gfx_RW,
  input  logic [ADDR_W-1:0] Gfx_Addr,
  input  logic [DATA_W-1:0] Gfx_WData,
  input  logic              Gfx_UDS_L,
  input  logic              Gfx_LDS_L,
  output logic              Gfx_Ack_H,
  output logic [DATA_W-1:0] Gfx_RData,
  output logic [ADDR_W-1:0] Sram_AddressOut,
  output logic [DATA_W-1:0] Sram_DataOut,
  input  logic [DATA_W-1:0] Sram_DataIn,
  output logic              Sram_RW_Out,
  output logic              Sram_UDS_Out_L,
  output logic              Sram_LDS_Out_L
);

  typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

  localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int STV_W = $clog2(GFX_STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(GFX_STARVE_LIMIT);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              gnt_gfx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, vid_rdata_q, gfx_rdata_q;
  logic              rw_q, uds_q, lds_q, vid_ack_q, gfx_ack_q;
  logic              gfx_win;

  // Graphics wins when video is absent or when it has waited through the full limit.
  assign gfx_win = Gfx_Req_H && ((starve_q == STV_MAX) || !Vid_Req_H);

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (!Gfx_Req_H || gfx_win)
        starve_d = '0;
      else if (Vid_Req_H && (starve_q != STV_MAX))
        starve_d = starve_q + 1'b1;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge Clk) begin
    if (Reset_H) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      gnt_gfx_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b1;
      uds_q       <= 1'b1;
      lds_q       <= 1'b1;
      vid_ack_q   <= 1'b0;
      gfx_ack_q   <= 1'b0;
      vid_rdata_q <= '0;
      gfx_rdata_q <= '0;
    end else begin
      vid_ack_q <= 1'b0;
      gfx_ack_q <= 1'b0;
      starve_q  <= starve_d;
      case (state_q)
        IDLE: begin
          if (Vid_Req_H || Gfx_Req_H) begin
            state_q   <= ACCESS;
            cnt_q     <= '0;
            gnt_gfx_q <= gfx_win;
            if (gfx_win) begin
              addr_q  <= Gfx_Addr;
              wdata_q <= Gfx_WData;
              rw_q    <= Gfx_RW;
              uds_q   <= Gfx_UDS_L;
              lds_q   <= Gfx_LDS_L;
            end else begin
              addr_q  <= Vid_Addr;
              rw_q    <= 1'b1;
              uds_q   <= 1'b0;
              lds_q   <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ACK;
            if (rw_q) begin
              if (gnt_gfx_q) gfx_rdata_q <= Sram_DataIn;
              else           vid_rdata_q <= Sram_DataIn;
            end
            vid_ack_q <= !gnt_gfx_q;
            gfx_ack_q <= gnt_gfx_q;
            // Release the bus controls now; address and data simply hold.
            rw_q  <= 1'b1;
            uds_q <= 1'b1;
            lds_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Vid_Ack_H       = vid_ack_q;
  assign Gfx_Ack_H       = gfx_ack_q;
  assign Vid_RData       = vid_rdata_q;
  assign Gfx_RData       = gfx_rdata_q;
  assign Sram_AddressOut = addr_q;
  assign Sram_DataOut    = wdata_q;
  assign Sram_RW_Out     = rw_q;
  assign Sram_UDS_Out_L  = uds_q;
  assign Sram_LDS_Out_L  = lds_q;

endmodule
